// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the MAXNET winner-take-all controller.
package maxnet_pkg;

  // Defaults shared with the datapath wrapper and the bench
  localparam int unsigned DEF_PU_LATENCY = 1;
  localparam int unsigned DEF_MAX_ITER   = 64;
  localparam int unsigned DEF_ITER_W     = 7;

  // Width of the PU latency down-counter (PU_LATENCY range 0..15)
  localparam int unsigned LAT_W = 4;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_EVAL = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/maxnet_latency_counter.sv
// Loadable 4-bit down-counter with zero flag; times the PU pipeline wait.
module latency_counter
  import maxnet_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] count,
  output logic             zero
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  // Load has priority; decrement stops at zero so the counter never wraps
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - LAT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/maxnet_controller.sv
// Sequencing FSM for the 4-neuron MAXNET datapath: memory init, initial X load,
// repeated PU-feedback loads separated by the PU latency, stop on winner or budget.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int unsigned PU_LATENCY = DEF_PU_LATENCY,
  parameter int unsigned MAX_ITER   = DEF_MAX_ITER,
  parameter int unsigned ITER_W     = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_finished,
  output logic              init_x,
  output logic              init_w,
  output logic              load_a,
  output logic              load_sel,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(PU_LATENCY);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
  localparam bit                NO_WAIT  = (PU_LATENCY == 0);

  state_t            state_q, state_d;
  logic              timeout_q, timeout_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic              lat_load;
  logic              lat_dec;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_zero;
  logic              lat_last;
  logic              at_max;
  logic              feedback;

  latency_counter u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .dec      (lat_dec),
    .load_val (LAT_LOAD),
    .count    (lat_cnt),
    .zero     (lat_zero)
  );

  // The zero term only guards against a stuck WAIT; in normal operation the
  // counter leaves WAIT on its last count of one.
  assign lat_last = (lat_cnt == LAT_W'(1)) || lat_zero;
  assign at_max   = (iter_q == ITER_MAX);
  // A feedback load happens in EVAL when there is no winner yet and budget remains
  assign feedback = (state_q == S_EVAL) && !is_finished && !at_max;

  // Next-state, iteration counter and timeout flag
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    iter_d    = iter_q;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_INIT;
          timeout_d = 1'b0;
          iter_d    = '0;
        end
      end
      S_INIT: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        lat_load = 1'b1;
        state_d  = NO_WAIT ? S_EVAL : S_WAIT;
      end
      S_WAIT: begin
        lat_dec = 1'b1;
        if (lat_last) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (is_finished) begin
          state_d = S_DONE;
        end else if (at_max) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          iter_d   = iter_q + ITER_W'(1);
          lat_load = 1'b1;
          state_d  = NO_WAIT ? S_EVAL : S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, iteration and timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timeout_q <= 1'b0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      iter_q    <= iter_d;
    end
  end

  // Outputs decode from the registered state; the EVAL load is additionally
  // gated by the winner/budget decision so PU_LATENCY=0 can load every cycle.
  assign init_x     = (state_q == S_INIT);
  assign init_w     = (state_q == S_INIT);
  assign load_a     = (state_q == S_LOAD) || feedback;
  assign load_sel   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign timeout    = timeout_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: one instance with PU_LATENCY=1/MAX_ITER=4,
// one with PU_LATENCY=0/MAX_ITER=8; expected cycle numbers are hand-derived.
module tb_maxnet_controller;

  logic clk;
  logic rst_n;
  logic start_v;
  logic fin_v;
  logic which;   // 0 -> instance a (L=1, M=4), 1 -> instance b (L=0, M=8)

  logic       a_start, a_fin, a_init_x, a_init_w, a_load_a, a_load_sel, a_busy, a_done, a_timeout;
  logic [2:0] a_iter;
  logic       b_start, b_fin, b_init_x, b_init_w, b_load_a, b_load_sel, b_busy, b_done, b_timeout;
  logic [3:0] b_iter;

  logic       m_init_x, m_init_w, m_load_a, m_load_sel, m_busy, m_done, m_timeout;
  logic [7:0] m_iter;

  int total = 0;
  int bad   = 0;

  // results of the last run
  int r_nloads, r_ninit, r_init_cyc, r_nsel, r_sel_cyc, r_ndone, r_done_cyc, r_expired;
  int r_load_cyc[16];
  logic [7:0] r_iter;
  logic       r_tmo, r_tmo_at1;

  assign a_start = start_v & ~which;
  assign a_fin   = fin_v & ~which;
  assign b_start = start_v & which;
  assign b_fin   = fin_v & which;

  maxnet_controller #(.PU_LATENCY(1), .MAX_ITER(4), .ITER_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .is_finished(a_fin),
    .init_x(a_init_x), .init_w(a_init_w), .load_a(a_load_a), .load_sel(a_load_sel),
    .busy(a_busy), .done(a_done), .timeout(a_timeout), .iter_count(a_iter)
  );

  maxnet_controller #(.PU_LATENCY(0), .MAX_ITER(8), .ITER_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .is_finished(b_fin),
    .init_x(b_init_x), .init_w(b_init_w), .load_a(b_load_a), .load_sel(b_load_sel),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .iter_count(b_iter)
  );

  // observe the selected instance
  always_comb begin
    m_init_x   = which ? b_init_x   : a_init_x;
    m_init_w   = which ? b_init_w   : a_init_w;
    m_load_a   = which ? b_load_a   : a_load_a;
    m_load_sel = which ? b_load_sel : a_load_sel;
    m_busy     = which ? b_busy     : a_busy;
    m_done     = which ? b_done     : a_done;
    m_timeout  = which ? b_timeout  : a_timeout;
    m_iter     = which ? {4'b0, b_iter} : {5'b0, a_iter};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a run at cycle 0 and watch it until it is back in IDLE.
  // fin_after: is_finished goes high once that many feedback loads were seen (-1 = never).
  // pulse_cyc: extra start pulse at that cycle. hold: keep start high throughout.
  task automatic run(input int fin_after, input int pulse_cyc, input bit hold);
    int cyc;
    r_nloads = 0; r_ninit = 0; r_init_cyc = -1; r_nsel = 0; r_sel_cyc = -1;
    r_ndone = 0; r_done_cyc = -1; r_expired = 1; r_iter = '1; r_tmo = 1'bx; r_tmo_at1 = 1'bx;
    for (int i = 0; i < 16; i++) r_load_cyc[i] = -1;
    cyc = 0;
    fin_v = (fin_after == 0);
    start_v = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      cyc++;
      start_v = hold || (cyc == pulse_cyc);
      fin_v = (fin_after >= 0) && (r_nloads >= fin_after);
      #1;
      if (cyc == 1) r_tmo_at1 = m_timeout;
      if (m_init_x && m_init_w) begin r_ninit++; r_init_cyc = cyc; end
      if (m_load_a && m_load_sel) begin r_nsel++; r_sel_cyc = cyc; end
      if (m_load_a && !m_load_sel) begin
        if (r_nloads < 16) r_load_cyc[r_nloads] = cyc;
        r_nloads++;
      end
      if (m_done) begin
        r_ndone++; r_done_cyc = cyc; r_iter = m_iter; r_tmo = m_timeout;
      end
      if (r_ndone > 0 && !m_busy) begin
        r_expired = 0;
        break;
      end
    end
    fin_v = 1'b0;
    $display("run inst=%0d loads=%0d done_cyc=%0d iter=%0d timeout=%0d",
             which, r_nloads, r_done_cyc, r_iter, r_tmo);
  endtask

  initial begin
    int drained;
    rst_n = 1'b0; start_v = 1'b0; fin_v = 1'b0; which = 1'b0;

    // power-on reset state
    #3;
    chk("por_busy", a_busy, 0);
    chk("por_done", a_done, 0);
    chk("por_load_a", a_load_a | b_load_a, 0);
    chk("por_init", a_init_x | a_init_w, 0);
    chk("por_iter", a_iter, 0);
    #9 rst_n = 1'b1;
    tick(); tick();
    chk("idle_after_por", a_busy, 0);

    // immediate winner, L=1
    run(0, -1, 1'b0);
    chk("imm_bound", r_expired, 0);
    chk("imm_init_cyc", r_init_cyc, 1);
    chk("imm_init_n", r_ninit, 1);
    chk("imm_sel_cyc", r_sel_cyc, 2);
    chk("imm_sel_n", r_nsel, 1);
    chk("imm_fb_loads", r_nloads, 0);
    chk("imm_done_cyc", r_done_cyc, 5);
    chk("imm_done_n", r_ndone, 1);
    chk("imm_iter", r_iter, 0);
    chk("imm_timeout", r_tmo, 0);

    // three feedback iterations, L=1
    run(3, -1, 1'b0);
    chk("it3_bound", r_expired, 0);
    chk("it3_loads", r_nloads, 3);
    chk("it3_load0", r_load_cyc[0], 4);
    chk("it3_load1", r_load_cyc[1], 6);
    chk("it3_load2", r_load_cyc[2], 8);
    chk("it3_done_cyc", r_done_cyc, 11);
    chk("it3_iter", r_iter, 3);
    chk("it3_timeout", r_tmo, 0);

    // budget exhausted, MAX_ITER=4
    run(-1, -1, 1'b0);
    chk("tmo_bound", r_expired, 0);
    chk("tmo_loads", r_nloads, 4);
    chk("tmo_load3", r_load_cyc[3], 10);
    chk("tmo_done_cyc", r_done_cyc, 13);
    chk("tmo_iter", r_iter, 4);
    chk("tmo_flag", r_tmo, 1);
    tick();
    chk("tmo_sticky", m_timeout, 1);
    chk("tmo_iter_held", m_iter, 4);
    run(0, -1, 1'b0);
    chk("tmo_cleared_on_start", r_tmo_at1, 0);
    chk("tmo_next_iter", r_iter, 0);
    chk("tmo_next_done_cyc", r_done_cyc, 5);

    // winner and budget in the same EVAL: winner wins
    run(4, -1, 1'b0);
    chk("tie_done_cyc", r_done_cyc, 13);
    chk("tie_iter", r_iter, 4);
    chk("tie_timeout", r_tmo, 0);

    // start pulsed while busy
    run(2, 3, 1'b0);
    chk("busy_start_init_n", r_ninit, 1);
    chk("busy_start_done_n", r_ndone, 1);
    chk("busy_start_loads", r_nloads, 2);
    chk("busy_start_done_cyc", r_done_cyc, 9);

    // start held through DONE: new run right after IDLE
    run(0, -1, 1'b1);
    chk("hold_done_cyc", r_done_cyc, 5);
    tick();
    chk("hold_restart_init", m_init_x, 1);
    start_v = 1'b0;
    fin_v = 1'b1;
    drained = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!m_busy) begin drained = 1; break; end
    end
    fin_v = 1'b0;
    chk("hold_drain", drained, 1);

    // asynchronous reset mid-run after two feedback loads
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("rst_mid_busy_before", m_busy, 1);
    chk("rst_mid_iter_before", m_iter, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", m_busy, 0);
    chk("rst_mid_iter", m_iter, 0);
    chk("rst_mid_outs", {m_load_a, m_load_sel, m_init_x, m_init_w, m_done, m_timeout}, 0);
    #2 rst_n = 1'b1;
    drained = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (m_busy || m_done) drained = 1;
    end
    chk("rst_mid_stays_idle", drained, 0);

    // PU_LATENCY=0: consecutive feedback loads
    which = 1'b1;
    tick();
    run(5, -1, 1'b0);
    chk("l0_bound", r_expired, 0);
    chk("l0_sel_cyc", r_sel_cyc, 2);
    chk("l0_loads", r_nloads, 5);
    chk("l0_load0", r_load_cyc[0], 3);
    chk("l0_load4", r_load_cyc[4], 7);
    chk("l0_done_cyc", r_done_cyc, 9);
    chk("l0_iter", r_iter, 5);

    // PU_LATENCY=0 budget exhausted, MAX_ITER=8
    run(-1, -1, 1'b0);
    chk("l0_tmo_loads", r_nloads, 8);
    chk("l0_tmo_done_cyc", r_done_cyc, 12);
    chk("l0_tmo_iter", r_iter, 8);
    chk("l0_tmo_flag", r_tmo, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
